aes256_inv_key_schedule: RTL
============================

// Module: aes256_inv_key_schedule
// PURPOSE
//  Reverse-direction AES-256 key schedule for the decrypt path. Takes the final round-key pair
//  (rk13, rk14) from the forward expander and regenerates round keys rk14 down to rk0, one per
//  rk_valid/rk_ready handshake, so the inverse cipher core gets keys in decryption order.
//  Iterative: one shared S-box, one 32-bit word computed per step.
// PARAMETERS
//  none (AES-256 fixed: Nk=8, 15 round keys, 60 words w[0..59])
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  start      in   1    1-cycle request; accepted only in IDLE
//  last_key   in   256  {w52,w53,w54,w55,w56,w57,w58,w59}, w52 at [255:224]; sampled on accepted start
//  busy       out  1    high from accepted start until rk0 handshake completes
//  rk_valid   out  1    round key on rk_data is valid
//  rk_ready   in   1    consumer accepts rk_data when rk_valid & rk_ready
//  rk_data    out  128  {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] at [127:96]
//  rk_index   out  4    round number r of rk_data (14 first, 0 last)
//  done       out  1    1-cycle pulse the cycle after rk0 handshake
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; busy, rk_valid, done = 0; rk_data = 0; rk_index = 0; window cleared.
//  Single clock; one transaction at a time. start while busy is ignored.
//  Window W[0..7] holds w[j+1..j+8] (W[0]=w[j+1]). Step computes w[j] for j = 51 down to 0:
//   j%8==0 : w[j] = w[j+8] ^ SubWord(RotWord(w[j+7])) ^ {Rcon[(j+8)/8],24'h0}
//   j%8==4 : w[j] = w[j+8] ^ SubWord(w[j+7])
//   else   : w[j] = w[j+8] ^ w[j+7]
//   then shift: W <= {w[j], W[0..6]} (w[j+8] dropped).
//  Rcon[1..7] = 01,02,04,08,10,20,40 (j=48 uses 40, j=0 uses 01).
//  FSM:
//   IDLE   -start-> LOAD (W <= w52..w59 from last_key; j <= 51)
//   LOAD   -> EMIT (rk_index=14, rk_data={w56..w59})
//   EMIT   hold rk_valid/rk_data/rk_index stable until handshake; on handshake:
//          r==14 -> EMIT r=13 ({w52..w55}); r==0 -> DONE; else -> CALC
//   CALC   j%4!=0: compute w[j] in 1 cycle; j%4==0 -> SUB
//   SUB    4 cycles, one byte per cycle through the shared S-box, MSB byte first,
//          after RotWord when j%8==0; -> COMB
//   COMB   XOR with w[j+8] and Rcon, shift window; same cycle as the CALC/COMB write
//   after writing w[j]: if j%4==0 -> EMIT r=j/4 with {w[j],w[j+1],w[j+2],w[j+3]}; else j<=j-1 -> CALC
//   DONE   done=1 for 1 cycle, busy<=0 -> IDLE
//  Latency: rk14 valid 2 cycles after accepted start. Per key with rk_ready held 1:
//   3 plain words (3 cycles) + 1 sub word (4 SUB + 1 COMB) + 1 handshake cycle. Total start->done fixed.
//  rk_valid never drops without handshake (AXI-stream style); rk_ready low stalls the engine
//  with no state change.
//  rk_valid & rk_ready simultaneous with state transition: new key appears next cycle, no bubble beyond 1.
//  rst_n asserted mid-operation: immediate abort to reset values; no done pulse; next start
//  restarts from scratch.
//  Byte/word order is FIPS-197 big-endian throughout; S-box is the standard forward AES S-box.
// TESTING
//  1. Key 000102..1f: drive forward-model (rk13,rk14) -> rk14=24fc79ccbf0979e9371ac23c6d68de36 first,
//     rk1=101112131415161718191a1b1c1d1e1f, rk0=000102030405060708090a0b0c0d0e0f, rk_index 14..0.
//  2. Key 603deb10..0914dff4 (FIPS-197 A.3): all 15 keys match golden model in reverse order;
//     rk0=603deb1015ca71be2b73aef0857d7781.
//  3. rk_ready random 30% duty: key sequence identical to case 1; rk_data/rk_index stable while
//     rk_valid & !rk_ready.
//  4. start pulsed again while busy (mid rk7) -> ignored, sequence completes unchanged, one done pulse.
//  5. rst_n low for 1 cycle during SUB of j=24 -> outputs at reset values immediately; new start with
//     case 2 key produces full correct sequence.
//  6. rk_ready tied 1: done exactly at fixed cycle count after start, busy low the cycle after done.

Source files
------------

// File: rtl/aes256_inv_key_schedule.sv
// Reverse AES-256 key expander: regenerates round keys rk14..rk0 from {w52..w59},
// one 32-bit word per step, sharing a single forward S-box over four byte cycles.
module aes256_inv_key_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] last_key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         done
);

  // Handshake: a round key transfers on any rising edge where rk_valid & rk_ready;
  // rk_valid, rk_data and rk_index stay frozen from assertion until that transfer.

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_EMIT = 3'd2;
  localparam logic [2:0] S_CALC = 3'd3;
  localparam logic [2:0] S_SUB  = 3'd4;
  localparam logic [2:0] S_COMB = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [2:0]  state;
  logic [31:0] win [8];   // win[0] = w[j+1] ... win[7] = w[j+8]
  logic [5:0]  j;
  logic [1:0]  byte_cnt;
  logic [31:0] sub_acc;

  logic [31:0] sub_src;
  logic [7:0]  sbox_in;
  logic [7:0]  sbox_out;
  logic [31:0] plain_w;
  logic [31:0] rcon_word;
  logic [31:0] comb_w;
  logic        handshake;

  always_comb begin
    sub_src   = (j[2:0] == 3'd0) ? {win[6][23:0], win[6][31:24]} : win[6];
    sbox_in   = sub_src[31:24];
    case (byte_cnt)
      2'd0:    sbox_in = sub_src[31:24];
      2'd1:    sbox_in = sub_src[23:16];
      2'd2:    sbox_in = sub_src[15:8];
      default: sbox_in = sub_src[7:0];
    endcase
    sbox_out  = SBOX[sbox_in];
    plain_w   = win[7] ^ win[6];
    // Rcon[(j+8)/8] = 0x01 << (j/8) for the rotated words only
    rcon_word = (j[2:0] == 3'd0) ? {(8'h01 << j[5:3]), 24'h0} : 32'h0;
    comb_w    = win[7] ^ sub_acc ^ rcon_word;
    handshake = rk_valid & rk_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_data  <= 128'h0;
      rk_index <= 4'd0;
      done     <= 1'b0;
      j        <= 6'd0;
      byte_cnt <= 2'd0;
      sub_acc  <= 32'h0;
      for (int k = 0; k < 8; k++) win[k] <= 32'h0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int k = 0; k < 8; k++) win[k] <= last_key[255-32*k -: 32];
            j     <= 6'd51;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          rk_data  <= {win[4], win[5], win[6], win[7]};
          rk_index <= 4'd14;
          rk_valid <= 1'b1;
          state    <= S_EMIT;
        end
        S_EMIT: begin
          if (handshake) begin
            if (rk_index == 4'd14) begin
              // rk13 is already sitting in the low half of the window
              rk_data  <= {win[0], win[1], win[2], win[3]};
              rk_index <= 4'd13;
            end else if (rk_index == 4'd0) begin
              rk_valid <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              rk_valid <= 1'b0;
              state    <= S_CALC;
            end
          end
        end
        S_CALC: begin
          win[0] <= plain_w;
          for (int k = 1; k < 8; k++) win[k] <= win[k-1];
          j        <= j - 6'd1;
          byte_cnt <= 2'd0;
          state    <= (j[1:0] == 2'd1) ? S_SUB : S_CALC;
        end
        S_SUB: begin
          sub_acc  <= {sub_acc[23:0], sbox_out};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) state <= S_COMB;
        end
        S_COMB: begin
          win[0] <= comb_w;
          for (int k = 1; k < 8; k++) win[k] <= win[k-1];
          rk_data  <= {comb_w, win[0], win[1], win[2]};
          rk_index <= j[5:2];
          rk_valid <= 1'b1;
          j        <= j - 6'd1;
          state    <= S_EMIT;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
